// File: rtl/result_display.sv
// Binary-to-decimal result display: double-dabble converter
// feeding a registered, prescaled 4-digit common-anode scanner.
module result_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] RESULT,
  input  logic        LOAD,
  output logic        BUSY,
  output logic [7:0]  SEG,
  output logic [3:0]  DIG
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_n;
  logic [15:0] bin, bin_n;
  logic [19:0] bcd, bcd_n;
  logic [19:0] adj;
  logic [3:0]  cnt, cnt_n;
  logic [19:0] shown, shown_n;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          blank;
  logic          ovf;
  logic [7:0]    seg_n;
  logic [3:0]    dig_n;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      shown <= '0;
    end else begin
      state <= state_n;
      bin   <= bin_n;
      bcd   <= bcd_n;
      cnt   <= cnt_n;
      shown <= shown_n;
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ?
                      bcd[4*i +: 4] + 4'd3 :
                      bcd[4*i +: 4];
    end
  end

  always_comb begin
    state_n = state;
    bin_n   = bin;
    bcd_n   = bcd;
    cnt_n   = cnt;
    shown_n = shown;
    unique case (state)
      IDLE: begin
        if (LOAD) begin
          state_n = CONV;
          bin_n   = RESULT;
          bcd_n   = '0;
          cnt_n   = '0;
        end
      end
      CONV: begin
        bcd_n = {adj[18:0], bin[15]};
        bin_n = {bin[14:0], 1'b0};
        cnt_n = cnt + 4'd1;
        // Publish only the finished value so no partial digits show
        if (cnt == 4'd15) begin
          state_n = IDLE;
          shown_n = {adj[18:0], bin[15]};
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign BUSY = (state == CONV);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PMAX) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign ovf = (shown[19:16] != 4'd0);

  always_comb begin
    nib   = shown[3:0];
    blank = 1'b0;
    unique case (idx)
      2'd0: begin
        nib   = shown[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = shown[7:4];
        blank = (shown[15:4] == 12'd0);
      end
      2'd2: begin
        nib   = shown[11:8];
        blank = (shown[15:8] == 8'd0);
      end
      2'd3: begin
        nib   = shown[15:12];
        blank = (shown[15:12] == 4'd0);
      end
      default: ;
    endcase
    seg_n = ovf   ? 8'h86 :
            blank ? 8'hFF : seg7(nib);
    dig_n = ~(4'b0001 << idx);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      SEG <= 8'hFF;
      DIG <= 4'hF;
    end else begin
      SEG <= seg_n;
      DIG <= dig_n;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: scan order, conversion
// latency, blanking, overflow, dropped loads and mid-run reset.
module tb_result_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] result = '0;
  logic        load = 1'b0;
  logic        busy;
  logic [7:0]  seg;
  logic [3:0]  dig;

  int total = 0;
  int bad = 0;
  logic [7:0] cap [4];

  result_display #(.SCAN_DIV(4)) dut (
    .CLK(clk),
    .RESET(rst_n),
    .RESULT(result),
    .LOAD(load),
    .BUSY(busy),
    .SEG(seg),
    .DIG(dig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    logic [7:0]  s3, s2, s1, s0;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic capture();
    for (int i = 0; i < 4; i++) cap[i] = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      unique case (dig)
        4'b1110: cap[0] = seg;
        4'b1101: cap[1] = seg;
        4'b1011: cap[2] = seg;
        4'b0111: cap[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic check_disp(input string name,
                            input logic [7:0] s3, s2, s1, s0);
    capture();
    chk({name, " d3"}, 32'(cap[3]), 32'(s3));
    chk({name, " d2"}, 32'(cap[2]), 32'(s2));
    chk({name, " d1"}, 32'(cap[1]), 32'(s1));
    chk({name, " d0"}, 32'(cap[0]), 32'(s0));
  endtask

  task automatic pulse_load(input logic [15:0] v);
    @(negedge clk);
    result = v;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [3:0] edig;

    tbl[0] = '{16'd1234,  8'hF9, 8'hA4, 8'hB0, 8'h99};
    tbl[1] = '{16'd7,     8'hFF, 8'hFF, 8'hFF, 8'hF8};
    tbl[2] = '{16'd1005,  8'hF9, 8'hC0, 8'hC0, 8'h92};
    tbl[3] = '{16'd10000, 8'h86, 8'h86, 8'h86, 8'h86};
    tbl[4] = '{16'd65535, 8'h86, 8'h86, 8'h86, 8'h86};
    tbl[5] = '{16'd9999,  8'h90, 8'h90, 8'h90, 8'h90};
    tbl[6] = '{16'd100,   8'hFF, 8'hF9, 8'hC0, 8'hC0};
    tbl[7] = '{16'd0,     8'hFF, 8'hFF, 8'hFF, 8'hC0};

    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset seg", 32'(seg), 32'hFF);
    chk("reset dig", 32'(dig), 32'hF);

    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      edig = ~(4'b0001 << (((e - 1) / 4) % 4));
      chk($sformatf("scan dig e%0d", e), 32'(dig), 32'(edig));
      chk($sformatf("scan seg e%0d", e), 32'(seg),
          (edig == 4'b1110) ? 32'hC0 : 32'hFF);
      chk($sformatf("scan busy e%0d", e), 32'(busy), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      pulse_load(tbl[i].v);
      count_busy(n);
      chk($sformatf("busy len %0d", tbl[i].v), 32'(n), 32'd16);
      check_disp($sformatf("val %0d", tbl[i].v),
                 tbl[i].s3, tbl[i].s2, tbl[i].s1, tbl[i].s0);
    end

    pulse_load(16'd1234);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 5) begin
        result = 16'd5678;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
    chk("drop busy len", 32'(n), 32'd16);
    repeat (5) @(negedge clk);
    chk("drop no reconv", 32'(busy), 32'd0);
    check_disp("drop disp", 8'hF9, 8'hA4, 8'hB0, 8'h99);

    pulse_load(16'd4321);
    repeat (8) @(negedge clk);
    chk("mid busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort seg", 32'(seg), 32'hFF);
    chk("abort dig", 32'(dig), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post rst busy", 32'(busy), 32'd0);
    check_disp("post rst", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
